// File: rtl/zbt_mem_arbiter.sv
// zbt_mem_arbiter: shares one pipelined ZBT SRAM port between four pixel clients
// Ports: clock, reset (synchronous, active-high)
//   cli_flag/cli_wr/cli_addr/cli_wdata : per-client request, slice i = client i
//   cli_done : per-client completion pulse; rd_data : read return (pass-through of mem_rdata)
//   mem_addr/mem_we/mem_wdata : registered SRAM command; mem_rdata : SRAM read data
//   stat_grants : four 16-bit grant counters when MEM_ARB_STATS_EN is defined, else 0
module zbt_mem_arbiter #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 36,
  parameter int READ_LAT = 2,
  parameter int N_CLI = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_CLI-1:0]      cli_flag,
  input  logic [N_CLI-1:0]      cli_wr,
  input  logic [N_CLI*ADDR_W-1:0] cli_addr,
  input  logic [N_CLI*DATA_W-1:0] cli_wdata,
  output logic [N_CLI-1:0]      cli_done,
  output logic [DATA_W-1:0]     rd_data,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [63:0]           stat_grants
);
  logic [N_CLI-1:0] pend, wr_q;
  logic [ADDR_W-1:0] addr_q [N_CLI];
  logic [DATA_W-1:0] wdata_q [N_CLI];
  logic [1:0] rr, sel, iss_cli;
  logic grant, iss_rd;
  logic [READ_LAT-1:0] tag_v;
  logic [1:0] tag_c [READ_LAT];

  function automatic logic [1:0] nxt(input logic [1:0] k);
    return k == 2'd3 ? 2'd1 : k + 2'd1;
  endfunction

  // client 0 wins outright; clients 1-3 are searched from rr, wrapping 3 -> 1
  always_comb begin
    grant = |pend;
    sel = pend[0] ? 2'd0 : pend[rr] ? rr : pend[nxt(rr)] ? nxt(rr) : nxt(nxt(rr));
  end

  always_ff @(posedge clock)
    for (int i = 0; i < N_CLI; i++)
      if (cli_flag[i] && !pend[i]) begin
        wr_q[i] <= cli_wr[i];
        addr_q[i] <= cli_addr[i*ADDR_W +: ADDR_W];
        wdata_q[i] <= cli_wdata[i*DATA_W +: DATA_W];
      end

  // iss_* marks the command on the bus this cycle; tag_* follows reads until data returns
  always_ff @(posedge clock)
    if (reset) begin
      pend <= '0;
      rr <= 2'd1;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      iss_rd <= 1'b0;
      iss_cli <= 2'd0;
      tag_v <= '0;
    end else begin
      for (int i = 0; i < N_CLI; i++)
        if (cli_flag[i] && !pend[i]) pend[i] <= 1'b1;
      if (grant) begin
        pend[sel] <= 1'b0;
        mem_addr <= addr_q[sel];
        mem_wdata <= wdata_q[sel];
        if (sel != 2'd0) rr <= nxt(sel);
      end
      mem_we <= grant && wr_q[sel];
      iss_rd <= grant && !wr_q[sel];
      iss_cli <= sel;
      tag_v <= (tag_v << 1) | READ_LAT'(iss_rd);
      tag_c[0] <= iss_cli;
      for (int j = 1; j < READ_LAT; j++) tag_c[j] <= tag_c[j-1];
    end

  always_comb begin
    cli_done = '0;
    for (int i = 0; i < N_CLI; i++)
      cli_done[i] = (mem_we && iss_cli == 2'(i)) || (tag_v[READ_LAT-1] && tag_c[READ_LAT-1] == 2'(i));
  end

  assign rd_data = mem_rdata;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] cnt [4];
  always_ff @(posedge clock)
    if (reset) cnt <= '{default: '0};
    else if (grant) cnt[sel] <= cnt[sel] + 16'd1;
  assign stat_grants = {cnt[3], cnt[2], cnt[1], cnt[0]};
`else
  assign stat_grants = '0;
`endif
endmodule

// File: tb/tb_zbt_mem_arbiter.sv
// tb_zbt_mem_arbiter: directed and randomized check of zbt_mem_arbiter against a behavioural model
module tb_zbt_mem_arbiter;
  localparam int AW = 19, DW = 36, L = 2;
  logic clock = 1'b0, reset = 1'b1;
  logic [3:0] cli_flag = '0, cli_wr = '0, cli_done;
  logic [4*AW-1:0] cli_addr = '0;
  logic [4*DW-1:0] cli_wdata = '0;
  logic [DW-1:0] rd_data, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic mem_we;
  logic [63:0] stat_grants;

  zbt_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(L), .N_CLI(4)) dut (
    .clock(clock), .reset(reset), .cli_flag(cli_flag), .cli_wr(cli_wr), .cli_addr(cli_addr),
    .cli_wdata(cli_wdata), .cli_done(cli_done), .rd_data(rd_data), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stat_grants(stat_grants));

  always #5 clock = ~clock;

  logic [DW-1:0] sram [64] = '{default: '0};
  logic [DW-1:0] rpipe [L];
  always @(posedge clock) begin
    if (mem_we) sram[mem_addr[5:0]] <= mem_wdata;
    rpipe[0] <= sram[mem_addr[5:0]];
    for (int j = 1; j < L; j++) rpipe[j] <= rpipe[j-1];
  end
  assign mem_rdata = rpipe[L-1];

  int checks = 0, errors = 0, cyc = 0;
  bit chk_en = 0;
  bit m_pend [4], m_wr [4];
  logic [AW-1:0] m_a [4];
  logic [DW-1:0] m_d [4];
  logic [DW-1:0] mm [64] = '{default: '0};
  int m_rr = 1;
  logic [15:0] m_cnt [4] = '{default: '0};
  logic [3:0] e_done [128] = '{default: '0};
  bit e_we [128], e_iss [128], e_rd [128];
  logic [AW-1:0] e_addr [128];
  logic [DW-1:0] e_wd [128], e_data [128];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input int i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cli_flag[i] = 1'b1;
    cli_wr[i] = w;
    cli_addr[i*AW +: AW] = a;
    cli_wdata[i*DW +: DW] = d;
  endtask

  task automatic model();
    bit p [4];
    int k, b, r;
    p = m_pend;
    if (reset) begin
      m_pend = '{default: 0};
      m_rr = 1;
      m_cnt = '{default: '0};
      for (int x = 0; x < 128; x++) begin
        e_done[x] = '0; e_we[x] = 0; e_iss[x] = 0; e_rd[x] = 0;
      end
      return;
    end
    k = -1;
    if (p[0]) k = 0;
    for (int n = 0; n < 3; n++)
      if (k < 0 && p[(m_rr - 1 + n) % 3 + 1]) k = (m_rr - 1 + n) % 3 + 1;
    if (k >= 0) begin
      b = (cyc + 1) % 128;
      e_iss[b] = 1; e_addr[b] = m_a[k]; e_we[b] = m_wr[k]; e_wd[b] = m_d[k];
      if (m_wr[k]) begin
        mm[m_a[k][5:0]] = m_d[k];
        e_done[b][k] = 1'b1;
      end else begin
        r = (cyc + 1 + L) % 128;
        e_done[r][k] = 1'b1; e_rd[r] = 1; e_data[r] = mm[m_a[k][5:0]];
      end
      m_pend[k] = 0;
      m_cnt[k] = m_cnt[k] + 16'd1;
      if (k > 0) m_rr = k % 3 + 1;
    end
    for (int i = 0; i < 4; i++)
      if (cli_flag[i] && !p[i]) begin
        m_pend[i] = 1; m_wr[i] = cli_wr[i];
        m_a[i] = cli_addr[i*AW +: AW]; m_d[i] = cli_wdata[i*DW +: DW];
      end
  endtask

  task automatic tick();
    int x;
    x = cyc % 128;
    if (chk_en) begin
      chk("done", 64'(cli_done), 64'(e_done[x]));
      chk("we", 64'(mem_we), 64'(e_we[x]));
      if (e_iss[x]) chk("addr", 64'(mem_addr), 64'(e_addr[x]));
      if (e_iss[x] && e_we[x]) chk("wdata", 64'(mem_wdata), 64'(e_wd[x]));
      if (e_rd[x]) chk("rdata", 64'(rd_data), 64'(e_data[x]));
    end
    e_done[x] = '0; e_we[x] = 0; e_iss[x] = 0; e_rd[x] = 0;
    @(posedge clock);
    model();
    cyc++;
    #1;
    cli_flag = '0;
  endtask

  task automatic chk_stats();
`ifdef MEM_ARB_STATS_EN
    chk("stats", stat_grants, {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]});
`else
    chk("stats", stat_grants, 64'd0);
`endif
  endtask

  initial begin
    bit last0;
    tick(); tick();
    reset = 1'b0;
    chk_en = 1;
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_done", 64'(cli_done), 64'd0);
    chk_stats();
    req(1, 1, 19'h00010, 36'h123456789);
    tick(); tick();
    chk("wr_we", 64'(mem_we), 64'd1);
    chk("wr_addr", 64'(mem_addr), 64'h10);
    chk("wr_data", 64'(mem_wdata), 64'h123456789);
    chk("wr_done", 64'(cli_done), 64'b0010);
    tick(); tick();
    req(3, 1, 19'h00020, 36'h00ABCDE);
    for (int n = 0; n < 4; n++) tick();
    req(2, 0, 19'h00020, 36'h0);
    for (int n = 0; n < 4; n++) tick();
    chk("rd_done", 64'(cli_done), 64'b0100);
    chk("rd_data", 64'(rd_data), 64'hABCDE);
    tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 1; i < 4; i++) req(i, 1, 19'(32'h100 + i), 36'(i));
      tick(); tick();
      chk("rr_first", 64'(mem_addr), r == 0 ? 64'h101 : 64'h102);
      tick();
      chk("rr_second", 64'(mem_addr), r == 0 ? 64'h102 : 64'h103);
      tick();
      chk("rr_third", 64'(mem_addr), r == 0 ? 64'h103 : 64'h101);
      tick(); tick();
      if (r == 0) begin
        req(1, 1, 19'h00005, 36'h5);
        for (int n = 0; n < 4; n++) tick();
      end
    end
    req(0, 1, 19'h00200, 36'h7);
    req(3, 1, 19'h00203, 36'h8);
    tick(); tick();
    chk("vga_first", 64'(mem_addr), 64'h200);
    chk("vga_done", 64'(cli_done), 64'b0001);
    tick();
    chk("vga_then3", 64'(mem_addr), 64'h203);
    tick(); tick();
    req(0, 0, 19'h00010, 36'h0);
    tick();
    req(2, 0, 19'h00020, 36'h0);
    tick(); tick(); tick();
    chk("b2b_done0", 64'(cli_done), 64'b0001);
    chk("b2b_data0", 64'(rd_data), 64'h123456789);
    tick();
    chk("b2b_done2", 64'(cli_done), 64'b0100);
    chk("b2b_data2", 64'(rd_data), 64'hABCDE);
    tick(); tick();
    chk_stats();
    req(0, 0, 19'h00010, 36'h0);
    tick();
    for (int i = 1; i < 4; i++) req(i, 1, 19'(i), 36'(i));
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst2_we", 64'(mem_we), 64'd0);
    chk_stats();
    for (int n = 0; n < 6; n++) begin
      chk("rst2_nodone", 64'(cli_done), 64'd0);
      tick();
    end
    last0 = 0;
    for (int n = 0; n < 600; n++) begin
      reset = $urandom_range(99, 0) == 0;
      for (int i = 0; i < 4; i++)
        if ($urandom_range(2, 0) == 0 && !(i == 0 && last0))
          req(i, 1'($urandom_range(1, 0)), 19'($urandom_range(7, 0)), {4'($urandom), 32'($urandom)});
      last0 = cli_flag[0];
      tick();
    end
    reset = 1'b0;
    for (int n = 0; n < 10; n++) tick();
    chk_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/zbt_mem_arbiter.md
Name: zbt_mem_arbiter

Overview:
Shares one pipelined ZBT SRAM port between four pixel clients: VGA read (client 0), NTSC write (client 1), LPF read (client 2) and projective-transform write (client 3).
- Clients use the same flag/done handshake as the LPF memory interface.
- The arbiter latches requests, issues at most one memory command per cycle, and routes each read's return data and done pulse back to the client that issued it.

Parameters:
ADDR_W, 19, memory word address width
DATA_W, 36, memory word width (two packed pixels plus spare bits)
READ_LAT, 2, cycles from mem_addr driven to mem_rdata valid
N_CLI, 4, number of clients (fixed; used for sizing only)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high
cli_flag  input  N_CLI  per-client request pulse, 1 cycle; bit i = client i
cli_wr  input  N_CLI  per-client write enable, sampled with flag
cli_addr  input  N_CLI*ADDR_W  per-client address; slice i, sampled with flag
cli_wdata  input  N_CLI*DATA_W  per-client write data; slice i, sampled with flag
cli_done  output  N_CLI  per-client completion pulse, 1 cycle
rd_data  output  DATA_W  read data, valid when a read client's done is high
mem_addr  output  ADDR_W  SRAM address, registered
mem_we  output  1  SRAM write enable, registered, active-high
mem_wdata  output  DATA_W  SRAM write data, registered
mem_rdata  input  DATA_W  SRAM read data
stat_grants  output  4*16  grant counters (see Optional Feature)

Behaviour:
Request capture
- On a clock edge with cli_flag[i]=1, latch wr/addr/wdata into slot i and set pend[i].
- A flag while pend[i]=1 is ignored; the earlier request is kept.

Arbitration
- Each cycle, combinationally select one pending slot.
- Client 0 has strict priority: VGA must never flag on consecutive cycles.
- Clients 1-3 are round-robin. Pointer rr starts at 1 after reset. Search order is rr, rr+1, ... wrapping 3→1. After a grant to client k in 1..3, rr becomes next(k).
- A VGA grant does not move rr.

Issue
- The selected slot's command is registered onto mem_addr/mem_we/mem_wdata at the edge, and pend[sel] clears at that same edge.
- Idle cycles: mem_we=0; mem_addr/mem_wdata hold their last values.

Latency, flag in cycle 0 with no contention
- Pend set at end of cycle 0.
- Command drives the memory bus in cycle 2.
- Write: cli_done[i] pulses in cycle 2.
- Read: cli_done[i] pulses in cycle 2+READ_LAT with rd_data = mem_rdata in that cycle (combinational pass-through).

Read tracking
- A READ_LAT-deep shift register of {valid, client id} follows each issued read.
- Reads and writes may be interleaved back to back. Done pulses are never merged, and at most one done bit is high per cycle from reads.
- A write done and a read done may coincide on different clients.

Boundary conditions
- Same-cycle new flag and grant on a different client: both take effect.
- A client re-flagging in the cycle its done pulses is legal.

Reset (reset wins over any flag)
- Clears pend, the tag pipeline and rr (to 1).
- Outputs after reset: cli_done=0, mem_we=0, mem_addr=0, mem_wdata=0, rd_data follows mem_rdata (don't-care).
- Reads in flight at reset produce no done.

Optional Feature:
Macro MEM_ARB_STATS_EN.
- Defined: stat_grants holds four 16-bit counters, slice i = grants issued to client i, wrapping at 65535→0, cleared by reset.
- Undefined: no counters are synthesized and stat_grants is tied to 0.

Test Plan:
- Single write: client 1 flag, addr 0x00010, wdata 0x123456789 in cycle 0 -> mem_we=1, mem_addr=0x00010 in cycle 2; cli_done=4'b0010 in cycle 2.
- Single read: client 2 flag, addr 0x00020, memory model returns 0xABCDE after 2 cycles -> cli_done=4'b0100 and rd_data=0xABCDE in cycle 4; no other done bit set.
- Contention: clients 1, 2, 3 flag in the same cycle -> grants in order 1, 2, 3 on consecutive cycles. Repeat with rr=2 -> order 2, 3, 1.
- VGA priority: clients 0 and 3 flag together -> client 0 issued first, client 3 next cycle; rr unchanged.
- Back-to-back reads: client 0 reads A, then client 2 reads B the next cycle -> done[0] with data(A), then done[2] with data(B) on consecutive cycles.
- Reset with pend=4'b1110 and one read in flight -> no done pulses afterward, mem_we=0; with MEM_ARB_STATS_EN, stat_grants=0.
